// File: rtl/qnna_pkg.sv
// Shared QNNA definitions: scheduler states, default tile geometry and the
// tile command record used by the MAC command port.
package qnna_pkg;

    localparam int unsigned QNNA_DIM_W  = 16;
    localparam int unsigned TILE_M_DEF  = 4;
    localparam int unsigned TILE_N_DEF  = 4;
    localparam int unsigned K_CHUNK_DEF = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIssue  = 2'd1,
        StWait   = 2'd2,
        StFinish = 2'd3
    } state_e;

    typedef struct packed {
        logic [QNNA_DIM_W-1:0] m0;
        logic [QNNA_DIM_W-1:0] n0;
        logic [QNNA_DIM_W-1:0] k0;
        logic [QNNA_DIM_W-1:0] m_len;
        logic [QNNA_DIM_W-1:0] n_len;
        logic [QNNA_DIM_W-1:0] k_len;
        logic                  first_k;
        logic                  last_k;
    } tile_cmd_t;

endpackage

// File: rtl/qnna_tile_ctr.sv
// One-dimension tile base counter: latches the dimension on clr, steps the base
// by TILE, wraps to zero after the last tile, and keeps a registered clipped length.
module qnna_tile_ctr #(
    parameter int unsigned DIM_W = 16,
    parameter int unsigned TILE  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             step,
    input  logic [DIM_W-1:0] dim,
    output logic [DIM_W-1:0] base,
    output logic [DIM_W-1:0] len,
    output logic             last
);

    localparam logic [DIM_W:0] TileW = (DIM_W + 1)'(TILE);

    logic [DIM_W-1:0] dim_q, dim_d, base_d, len_d;
    logic [DIM_W:0]   reach;
    logic             last_d;

    always_comb begin
        dim_d = clr ? dim : dim_q;
        if (clr || last) begin
            base_d = '0;
        end else begin
            base_d = base + TileW[DIM_W-1:0];
        end
        // One extra bit so a dimension near the top of the range cannot wrap.
        reach  = {1'b0, base_d} + TileW;
        last_d = (reach >= {1'b0, dim_d});
        len_d  = last_d ? (dim_d - base_d) : TileW[DIM_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dim_q <= '0;
            base  <= '0;
            len   <= '0;
            last  <= 1'b0;
        end else if (clr || step) begin
            dim_q <= dim_d;
            base  <= base_d;
            len   <= len_d;
            last  <= last_d;
        end
    end

endmodule

// File: rtl/qnna_tile_sched.sv
// Tile scheduler: walks an M x N x K job in tiles (K innermost, then N, then M),
// issuing one command per step and waiting for mac_done between commands.
module qnna_tile_sched
    import qnna_pkg::*;
#(
    parameter int unsigned DIM_W   = QNNA_DIM_W,
    parameter int unsigned TILE_M  = TILE_M_DEF,
    parameter int unsigned TILE_N  = TILE_N_DEF,
    parameter int unsigned K_CHUNK = K_CHUNK_DEF,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [DIM_W-1:0] dim_m,
    input  logic [DIM_W-1:0] dim_n,
    input  logic [DIM_W-1:0] dim_k,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             tile_valid,
    input  logic             tile_ready,
    output logic [DIM_W-1:0] tile_m0,
    output logic [DIM_W-1:0] tile_n0,
    output logic [DIM_W-1:0] tile_k0,
    output logic [DIM_W-1:0] tile_m_len,
    output logic [DIM_W-1:0] tile_n_len,
    output logic [DIM_W-1:0] tile_k_len,
    output logic             tile_first_k,
    output logic             tile_last_k,
    input  logic             mac_done,
    output logic [CNT_W-1:0] cmd_count
);

    state_e state_q, state_d;
    logic   dims_ok, clr, advance, last_cmd, cmd_complete;
    logic   m_last, n_last;

    assign dims_ok      = (dim_m != '0) && (dim_n != '0) && (dim_k != '0);
    assign clr          = (state_q == StIdle) && start && dims_ok;
    assign cmd_complete = (state_q == StWait) && mac_done && !abort;
    assign last_cmd     = m_last && n_last && tile_last_k;
    assign advance      = cmd_complete && !last_cmd;

    qnna_tile_ctr #(.DIM_W(DIM_W), .TILE(K_CHUNK)) u_ctr_k (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .step (advance),
        .dim  (dim_k),
        .base (tile_k0),
        .len  (tile_k_len),
        .last (tile_last_k)
    );

    qnna_tile_ctr #(.DIM_W(DIM_W), .TILE(TILE_N)) u_ctr_n (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .step (advance && tile_last_k),
        .dim  (dim_n),
        .base (tile_n0),
        .len  (tile_n_len),
        .last (n_last)
    );

    qnna_tile_ctr #(.DIM_W(DIM_W), .TILE(TILE_M)) u_ctr_m (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .step (advance && tile_last_k && n_last),
        .dim  (dim_m),
        .base (tile_m0),
        .len  (tile_m_len),
        .last (m_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start) state_d = dims_ok ? StIssue : StFinish;
            StIssue:  if (tile_ready) state_d = StWait;
            StWait:   if (mac_done) state_d = last_cmd ? StFinish : StIssue;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (abort && (state_q != StIdle)) state_d = StIdle;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            tile_valid   <= 1'b0;
            tile_first_k <= 1'b0;
            cmd_count    <= '0;
        end else begin
            state_q    <= state_d;
            busy       <= (state_d == StIssue) || (state_d == StWait);
            done       <= (state_d == StFinish);
            tile_valid <= (state_d == StIssue);
            if ((state_q == StIdle) && start) err <= !dims_ok;
            if (clr) begin
                cmd_count <= '0;
            end else if (cmd_complete) begin
                cmd_count <= cmd_count + CNT_W'(1);
            end
            // K wraps to zero exactly when the slice just finished was the last one.
            if (clr) begin
                tile_first_k <= 1'b1;
            end else if (advance) begin
                tile_first_k <= tile_last_k;
            end
        end
    end

endmodule

// File: tb/tb_qnna_tile_sched.sv
// Bench for qnna_tile_sched: table of jobs plus random jobs checked against a
// nested-loop command model, and hand sequences for stall, abort and error cases.
module tb_qnna_tile_sched;

    localparam int DW = 16;
    localparam int TM = 4;
    localparam int TN = 4;
    localparam int TK = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, abort, tile_ready, mac_done;
    logic [DW-1:0] dim_m, dim_n, dim_k;
    logic          busy, done, err, tile_valid, tile_first_k, tile_last_k;
    logic [DW-1:0] tile_m0, tile_n0, tile_k0, tile_m_len, tile_n_len, tile_k_len;
    logic [31:0]   cmd_count;

    always #5 clk = ~clk;

    qnna_tile_sched #(
        .DIM_W   (DW),
        .TILE_M  (TM),
        .TILE_N  (TN),
        .K_CHUNK (TK),
        .CNT_W   (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .dim_m        (dim_m),
        .dim_n        (dim_n),
        .dim_k        (dim_k),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .tile_valid   (tile_valid),
        .tile_ready   (tile_ready),
        .tile_m0      (tile_m0),
        .tile_n0      (tile_n0),
        .tile_k0      (tile_k0),
        .tile_m_len   (tile_m_len),
        .tile_n_len   (tile_n_len),
        .tile_k_len   (tile_k_len),
        .tile_first_k (tile_first_k),
        .tile_last_k  (tile_last_k),
        .mac_done     (mac_done),
        .cmd_count    (cmd_count)
    );

    typedef struct {
        int m, n, k, total;
        bit rnd, stall;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [97:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [97:0] fields();
        return {tile_m0, tile_n0, tile_k0, tile_m_len, tile_n_len, tile_k_len,
                tile_first_k, tile_last_k};
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Reference command list straight from the iteration rules.
    function automatic void build(input int m, input int n, input int k);
        exp_q.delete();
        for (int a = 0; a < m; a += TM)
            for (int b = 0; b < n; b += TN)
                for (int c = 0; c < k; c += TK)
                    exp_q.push_back({16'(a), 16'(b), 16'(c), 16'(min2(TM, m - a)),
                                     16'(min2(TN, n - b)), 16'(min2(TK, k - c)),
                                     (c == 0), (c + TK >= k)});
    endfunction

    task automatic run_job(input int m, input int n, input int k, input int total,
                           input bit rnd, input bit stall);
        logic [97:0] snap;
        dim_m = 16'(m);
        dim_n = 16'(n);
        dim_k = 16'(k);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (total == 0) begin
            check("zero_err", err, 1);
            check("zero_done", done, 1);
            check("zero_valid", tile_valid, 0);
            check("zero_busy", busy, 0);
            tick();
            check("zero_done_drop", done, 0);
            check("zero_valid2", tile_valid, 0);
            return;
        end
        check("busy_on", busy, 1);
        check("err_clr", err, 0);
        build(m, n, k);
        for (int i = 0; i < exp_q.size(); i++) begin
            check("tile_valid", tile_valid, 1);
            if (!tile_valid) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                return;
            end
            check($sformatf("cmd%0d", i), fields(), exp_q[i]);
            if (stall && i == 0) begin
                snap = fields();
                for (int s = 0; s < 5; s++) begin
                    mac_done = (s == 2);
                    tick();
                    mac_done = 1'b0;
                    check("stall_valid", tile_valid, 1);
                    check("stall_fields", fields(), exp_q[0]);
                    check("stall_count", cmd_count, 0);
                end
            end else if (rnd) begin
                repeat ($urandom_range(0, 2)) tick();
                check("hold_fields", fields(), exp_q[i]);
            end
            tile_ready = 1'b1;
            tick();
            tile_ready = 1'b0;
            if (total < 1000) begin
                check("wait_valid_low", tile_valid, 0);
                check("wait_busy", busy, 1);
            end
            if (rnd) repeat ($urandom_range(0, 2)) tick();
            mac_done = 1'b1;
            tick();
            mac_done = 1'b0;
            check("cmd_count", cmd_count, i + 1);
            if (i == exp_q.size() - 1) begin
                check("done_pulse", done, 1);
                check("busy_off", busy, 0);
                tick();
                check("done_drop", done, 0);
            end else if (total < 1000) begin
                check("gap_busy", busy, 1);
            end
        end
        check("total", cmd_count, total);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   m, n, k;
        tbl[0] = '{m: 4,     n: 4,  k: 4,  total: 1,     rnd: 0, stall: 0};
        tbl[1] = '{m: 5,     n: 4,  k: 8,  total: 4,     rnd: 0, stall: 1};
        tbl[2] = '{m: 4,     n: 0,  k: 4,  total: 0,     rnd: 0, stall: 0};
        tbl[3] = '{m: 7,     n: 9,  k: 3,  total: 6,     rnd: 1, stall: 0};
        tbl[4] = '{m: 16,    n: 5,  k: 13, total: 32,    rnd: 1, stall: 0};
        tbl[5] = '{m: 1,     n: 1,  k: 1,  total: 1,     rnd: 1, stall: 0};
        tbl[6] = '{m: 3,     n: 17, k: 4,  total: 5,     rnd: 1, stall: 0};
        tbl[7] = '{m: 65535, n: 1,  k: 1,  total: 16384, rnd: 0, stall: 0};

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        tile_ready = 1'b0;
        mac_done = 1'b0;
        dim_m = '0;
        dim_n = '0;
        dim_k = '0;
        tick();
        tick();
        check("reset_ctrl", {busy, done, err, tile_valid}, 0);
        check("reset_fields", fields(), 0);
        check("reset_count", cmd_count, 0);
        rst = 1'b0;
        tick();

        for (int t = 0; t < 8; t++) begin
            run_job(tbl[t].m, tbl[t].n, tbl[t].k, tbl[t].total, tbl[t].rnd, tbl[t].stall);
            tick();
        end

        // Abort in WAIT together with mac_done, then restart on the very next cycle.
        dim_m = 16'd5;
        dim_n = 16'd4;
        dim_k = 16'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        tile_ready = 1'b1;
        tick();
        tile_ready = 1'b0;
        mac_done = 1'b1;
        tick();
        mac_done = 1'b0;
        check("abort_pre_count", cmd_count, 1);
        tile_ready = 1'b1;
        tick();
        tile_ready = 1'b0;
        abort = 1'b1;
        mac_done = 1'b1;
        tick();
        abort = 1'b0;
        mac_done = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", tile_valid, 0);
        check("abort_done", done, 0);
        check("abort_count", cmd_count, 1);
        check("abort_err", err, 0);
        run_job(5, 4, 8, 4, 1, 0);
        tick();

        for (int r = 0; r < 6; r++) begin
            m = $urandom_range(1, 12);
            n = $urandom_range(1, 12);
            k = $urandom_range(1, 12);
            run_job(m, n, k, ((m + TM - 1) / TM) * ((n + TN - 1) / TN) * ((k + TK - 1) / TK),
                    1, 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
